key_search_sequencer: RTL and testbench
=======================================

Name: key_search_sequencer

Overview:
- Top-level scheduler for the RC4 key-search datapath. It drives the 6-bit mode word and key into the RAM controller, and sequences init -> shuffle -> decrypt for each candidate key.
- After each decrypt it reads the success flag, then either stops with the found key or steps to the next candidate until the range is exhausted.
- Several instances with different key_base/KEY_STEP values split the key space across parallel cores.

Parameters:
- RAM_WIDTH, 8, bits per key byte.
- KEY_LENGTH, 3, key bytes; counter width KW = KEY_LENGTH*RAM_WIDTH.
- KEY_MAX, 24'h3FFFFF, last legal key value (KW bits).
- KEY_STEP, 1, key increment per attempt (core interleave).
- NUM_DEVICES, 3, width of finish_bus.
- TIMEOUT_CYCLES, 4096, per-phase watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- start  in  1  one-cycle pulse that starts a search; honoured only in IDLE, FOUND, EXHAUSTED.
- abort  in  1  level; stop the search and return to IDLE.
- key_base  in  KW  first candidate key; sampled on an accepted start.
- finish_bus  in  NUM_DEVICES  finished flags from initializer[0], shuffler[1], decryptor[2].
- success  in  1  decryptor verdict; valid when finish_bus[2]=1.
- mode  out  6  6'b000_000 idle, 6'b001_000 init, 6'b010_000 shuffle, 6'b011_000 decrypt.
- key  out  [KEY_LENGTH-1:0][RAM_WIDTH-1:0]  current candidate; the flat vector equals the counter, so key[0] is the LS byte.
- busy  out  1  high from accepted start until FOUND, EXHAUSTED or IDLE.
- found  out  1  sticky; key holds the winning value.
- exhausted  out  1  sticky; no key in range passed.
- attempts  out  KW  count of completed decrypt phases in this search.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State IDLE.
  - mode=0, key=0, busy=0, found=0, exhausted=0, attempts=0.
- All outputs are registered; mode and key change only on clk edges.
- States:
  - IDLE, INIT, GAP1, SHUF, GAP2, DECR, CHECK, FOUND, EXHAUSTED.
- IDLE/FOUND/EXHAUSTED + start:
  - key<=key_base, attempts<=0, found<=0, exhausted<=0, busy<=1, go to INIT.
  - mode=001_000 is visible in the cycle after start.
- If key_base > KEY_MAX at start:
  - Go directly to EXHAUSTED on the next cycle, with mode staying 0.
- INIT (mode 001_000):
  - Wait for finish_bus[0], then go to GAP1.
- GAP1 (mode 0):
  - Lasts exactly 1 cycle, so the device start level drops. Then go to SHUF.
- SHUF (mode 010_000):
  - Wait for finish_bus[1], then go to GAP2.
- GAP2 (mode 0):
  - Lasts 1 cycle, then go to DECR.
- DECR (mode 011_000):
  - Wait for finish_bus[2].
  - On that edge, latch success and increment attempts (saturating at all-ones), then go to CHECK.
- Stale-finish rule:
  - In INIT, SHUF and DECR, the finish bit is ignored in the first cycle of the phase.
  - It is accepted from the 2nd phase cycle on, so a level left high by the prior phase cannot skip a phase.
- CHECK (mode 0, 1 cycle):
  - If latched success: found<=1, busy<=0, key held, go to FOUND.
  - Else if key > KEY_MAX-KEY_STEP: exhausted<=1, busy<=0, go to EXHAUSTED. This is computed in KW+1 bits so there is no wrap-around.
  - Else key<=key+KEY_STEP, go to INIT.
- Key stability:
  - key is constant across the whole INIT..CHECK sequence for one candidate.
  - key changes only on the CHECK->INIT edge or on an accepted start.
- abort:
  - Active in INIT..CHECK: on the next edge, state IDLE, mode 0, busy 0. key, attempts and flags are held.
  - abort beats success in the same CHECK cycle.
  - abort has no effect in FOUND or EXHAUSTED.
- Simultaneous start and abort in IDLE: abort wins; the sequencer stays in IDLE.
- Finish bits for inactive phases are ignored.
- success outside DECR is ignored.
- reset mid-search: all outputs return to reset values on that edge, regardless of state.

Optional Feature:
- Macro: KEYSEQ_WATCHDOG_EN.
- Defined:
  - A phase counter clears on entry to INIT, SHUF and DECR.
  - If the counter reaches TIMEOUT_CYCLES without the phase's finish bit, go to state FAULT.
  - FAULT: mode 0, busy 0, output fault=1 (extra 1-bit port, reset 0).
  - FAULT is left only by start (clears fault) or by reset.
- Undefined:
  - No counter, no fault port, no FAULT state; phases wait indefinitely.

Test Plan:
1. Key found: start, key_base=24'h000010; model success=1 on the 3rd decrypt.
   - Mode sequence is 001,0,010,0,011,0 per key.
   - Final: found=1, key=24'h000012, attempts=3, busy=0.
2. Range end: KEY_MAX=24'h000005, key_base=24'h000004, KEY_STEP=1, success always 0.
   - Two attempts, exhausted=1, key=24'h000005, attempts=2.
3. Interleave overflow: KEY_STEP=4, KEY_MAX=24'h3FFFFF, key_base=24'h3FFFFD, success=0.
   - One attempt, exhausted=1, key=24'h3FFFFD (no wrap to 1).
4. Stale finish: hold finish_bus=3'b111 constantly.
   - Each phase lasts exactly 2 cycles; no phase is skipped; GAP cycles show mode=0.
5. Abort during SHUF, key=24'h000020:
   - Next edge: IDLE, mode=0, busy=0, key=24'h000020.
   - A following start with key_base=0 restarts at INIT with key=0, attempts=0.
6. Reset during DECR (reset=0 for 1 cycle):
   - All outputs are 0 on that edge.
   - With KEYSEQ_WATCHDOG_EN and TIMEOUT_CYCLES=16, withholding finish_bus[1] gives fault=1 after 16 SHUF cycles.

Source files
------------

// File: rtl/key_search_sequencer_if.sv
// Datapath-side bus between the key-search sequencer and the RAM controller / RC4 devices.
interface key_search_sequencer_if #(
    parameter int unsigned RAM_WIDTH   = 8,
    parameter int unsigned KEY_LENGTH  = 3,
    parameter int unsigned NUM_DEVICES = 3
) ();
    logic [5:0]                           mode;
    logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key;
    logic [NUM_DEVICES-1:0]               finish_bus;
    logic                                 success;

    modport master (output mode, output key, input finish_bus, input success);
    modport slave  (input mode, input key, output finish_bus, output success);
endinterface

// File: rtl/key_search_sequencer.sv
// RC4 key-search scheduler: walks candidate keys through init -> shuffle -> decrypt until found or exhausted.
// Optional per-phase watchdog with a FAULT state is enabled by defining KEYSEQ_WATCHDOG_EN.
module key_search_sequencer #(
    parameter int unsigned                         RAM_WIDTH   = 8,
    parameter int unsigned                         KEY_LENGTH  = 3,
    parameter logic [RAM_WIDTH*KEY_LENGTH-1:0]     KEY_MAX     = 24'h3FFFFF,
    parameter int unsigned                         KEY_STEP    = 1,
    parameter int unsigned                         NUM_DEVICES = 3
`ifdef KEYSEQ_WATCHDOG_EN
    ,
    parameter int unsigned                         TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               abort,
    input  logic [RAM_WIDTH*KEY_LENGTH-1:0]    key_base,
    key_search_sequencer_if.master             bus,
    output logic                               busy,
    output logic                               found,
    output logic                               exhausted,
    output logic [RAM_WIDTH*KEY_LENGTH-1:0]    attempts
`ifdef KEYSEQ_WATCHDOG_EN
    ,
    output logic                               fault
`endif
);

    localparam int unsigned KW  = RAM_WIDTH * KEY_LENGTH;
    localparam int unsigned KW1 = KW + 1;

    localparam logic [5:0] MODE_IDLE = 6'b000_000;
    localparam logic [5:0] MODE_INIT = 6'b001_000;
    localparam logic [5:0] MODE_SHUF = 6'b010_000;
    localparam logic [5:0] MODE_DECR = 6'b011_000;

    localparam logic [KW:0]   KEY_MAX_X = {1'b0, KEY_MAX};
    localparam logic [KW:0]   STEP_X    = KW1'(KEY_STEP);
    localparam logic [KW-1:0] STEP_K    = KW'(KEY_STEP);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_GAP1,
        S_SHUF,
        S_GAP2,
        S_DECR,
        S_CHECK,
        S_FOUND,
        S_EXHAUSTED
`ifdef KEYSEQ_WATCHDOG_EN
        ,
        S_FAULT
`endif
    } state_t;

    state_t          state;
    logic [5:0]      mode_r;
    logic [KW-1:0]   key_r;
    logic            success_q;
    logic            first_q;

    logic            fin_init;
    logic            fin_shuf;
    logic            fin_decr;
    logic            last_key;
    logic            can_start;

    assign bus.mode = mode_r;
    assign bus.key  = key_r;

    // A finish level is only trusted from the second cycle of a phase on.
    assign fin_init = bus.finish_bus[0] && !first_q;
    assign fin_shuf = bus.finish_bus[1] && !first_q;
    assign fin_decr = bus.finish_bus[2] && !first_q;

    // Widened by one bit so key+step cannot wrap past KEY_MAX.
    assign last_key = ({1'b0, key_r} + STEP_X) > KEY_MAX_X;

    always_comb begin
        can_start = (state == S_IDLE) || (state == S_FOUND) || (state == S_EXHAUSTED);
`ifdef KEYSEQ_WATCHDOG_EN
        if (state == S_FAULT) can_start = 1'b1;
`endif
    end

`ifdef KEYSEQ_WATCHDOG_EN
    localparam int unsigned PW = $clog2(TIMEOUT_CYCLES + 1);

    logic [PW-1:0] phase_cnt;
    logic          wd_trip;

    assign wd_trip = (phase_cnt == PW'(TIMEOUT_CYCLES - 1)) &&
                     (((state == S_INIT) && !fin_init) ||
                      ((state == S_SHUF) && !fin_shuf) ||
                      ((state == S_DECR) && !fin_decr));
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            mode_r    <= MODE_IDLE;
            key_r     <= '0;
            busy      <= 1'b0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            attempts  <= '0;
            success_q <= 1'b0;
            first_q   <= 1'b0;
`ifdef KEYSEQ_WATCHDOG_EN
            phase_cnt <= '0;
            fault     <= 1'b0;
`endif
        end else begin
            first_q <= 1'b0;
`ifdef KEYSEQ_WATCHDOG_EN
            phase_cnt <= phase_cnt + PW'(1);
`endif
            if (can_start) begin
                // Abort only blocks a start while idle; terminal states ignore it.
                if (start && !(abort && (state == S_IDLE))) begin
                    key_r    <= key_base;
                    attempts <= '0;
                    found    <= 1'b0;
`ifdef KEYSEQ_WATCHDOG_EN
                    fault     <= 1'b0;
                    phase_cnt <= '0;
`endif
                    if (key_base > KEY_MAX) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        mode_r    <= MODE_IDLE;
                        state     <= S_EXHAUSTED;
                    end else begin
                        exhausted <= 1'b0;
                        busy      <= 1'b1;
                        mode_r    <= MODE_INIT;
                        first_q   <= 1'b1;
                        state     <= S_INIT;
                    end
                end
            end else if (abort) begin
                state  <= S_IDLE;
                mode_r <= MODE_IDLE;
                busy   <= 1'b0;
            end
`ifdef KEYSEQ_WATCHDOG_EN
            else if (wd_trip) begin
                state  <= S_FAULT;
                mode_r <= MODE_IDLE;
                busy   <= 1'b0;
                fault  <= 1'b1;
            end
`endif
            else begin
                case (state)
                    S_INIT: begin
                        if (fin_init) begin
                            mode_r <= MODE_IDLE;
                            state  <= S_GAP1;
                        end
                    end
                    S_GAP1: begin
                        mode_r  <= MODE_SHUF;
                        first_q <= 1'b1;
`ifdef KEYSEQ_WATCHDOG_EN
                        phase_cnt <= '0;
`endif
                        state   <= S_SHUF;
                    end
                    S_SHUF: begin
                        if (fin_shuf) begin
                            mode_r <= MODE_IDLE;
                            state  <= S_GAP2;
                        end
                    end
                    S_GAP2: begin
                        mode_r  <= MODE_DECR;
                        first_q <= 1'b1;
`ifdef KEYSEQ_WATCHDOG_EN
                        phase_cnt <= '0;
`endif
                        state   <= S_DECR;
                    end
                    S_DECR: begin
                        if (fin_decr) begin
                            success_q <= bus.success;
                            if (attempts != '1) attempts <= attempts + KW'(1);
                            mode_r    <= MODE_IDLE;
                            state     <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (success_q) begin
                            found <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_FOUND;
                        end else if (last_key) begin
                            exhausted <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_EXHAUSTED;
                        end else begin
                            key_r   <= key_r + STEP_K;
                            mode_r  <= MODE_INIT;
                            first_q <= 1'b1;
`ifdef KEYSEQ_WATCHDOG_EN
                            phase_cnt <= '0;
`endif
                            state   <= S_INIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_search_sequencer.sv
// Self-checking bench: three sequencer instances (default, short range, step-4 interleave) driven by a
// randomized datapath responder and compared against an arithmetic key-search model.
`timescale 1ns/1ps
module tb_key_search_sequencer;

    localparam int unsigned KW      = 24;
    localparam int unsigned KW1     = KW + 1;
    localparam int          ND      = 3;
    localparam int          MAX_ATT = 8;

    localparam logic [5:0] M_IDLE = 6'b000_000;
    localparam logic [5:0] M_INIT = 6'b001_000;
    localparam logic [5:0] M_SHUF = 6'b010_000;
    localparam logic [5:0] M_DECR = 6'b011_000;

    localparam logic [KW-1:0] KMAX   [ND] = '{24'h3FFFFF, 24'h000005, 24'h3FFFFF};
    localparam int unsigned   STEP_I [ND] = '{1, 1, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          abort;
    logic          start_v [ND];
    logic [KW-1:0] base_v  [ND];
    logic [2:0]    fin_v   [ND];
    logic          suc_v   [ND];
    logic [5:0]    mode_v  [ND];
    logic [KW-1:0] key_v   [ND];
    logic [KW-1:0] att_v   [ND];
    logic          busy_v  [ND];
    logic          found_v [ND];
    logic          exh_v   [ND];
`ifdef KEYSEQ_WATCHDOG_EN
    logic          fault_v [ND];
`endif

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        key_search_sequencer_if #(.RAM_WIDTH(8), .KEY_LENGTH(3), .NUM_DEVICES(3)) bus ();
        assign bus.finish_bus = fin_v[g];
        assign bus.success    = suc_v[g];
        assign mode_v[g]      = bus.mode;
        assign key_v[g]       = bus.key;

        key_search_sequencer #(
            .KEY_MAX  (KMAX[g]),
            .KEY_STEP (STEP_I[g])
`ifdef KEYSEQ_WATCHDOG_EN
            ,
            .TIMEOUT_CYCLES(16)
`endif
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start_v[g]),
            .abort     (abort),
            .key_base  (base_v[g]),
            .bus       (bus.master),
            .busy      (busy_v[g]),
            .found     (found_v[g]),
            .exhausted (exh_v[g]),
            .attempts  (att_v[g])
`ifdef KEYSEQ_WATCHDOG_EN
            ,
            .fault     (fault_v[g])
`endif
        );
    end

    function automatic logic [2:0] phase_bit(input logic [5:0] m);
        case (m)
            M_INIT:  return 3'b001;
            M_SHUF:  return 3'b010;
            M_DECR:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic pulse_start(input int d, input logic [KW-1:0] base);
        base_v[d]  = base;
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    // Finishes every phase immediately until the instance shows the target mode.
    task automatic advance_to(input int d, input logic [5:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mode_v[d] === target) begin
                ok = 1'b1;
                fin_v[d] = 3'b000;
                return;
            end
            fin_v[d] = phase_bit(mode_v[d]);
            @(negedge clk);
        end
        fin_v[d] = 3'b000;
    endtask

    // Full search with the mode trace compared run-by-run against the model.
    task automatic run_search(input int d, input logic [KW-1:0] base, input int succ,
                              input bit hold, input string name);
        logic [KW:0]   k;
        logic [KW-1:0] cand;
        logic [KW-1:0] exp_key;
        int            n;
        bit            exp_found;
        int            lat [MAX_ATT][3];
        logic [5:0]    exp_val [$];
        int            exp_len [$];
        logic [KW-1:0] exp_k   [$];
        logic [5:0]    ph_mode [3];
        logic [5:0]    m, cur, ev;
        logic [KW-1:0] run_key, ek;
        int            idx, len, att, el;
        bit            done;

        ph_mode = '{M_INIT, M_SHUF, M_DECR};
        k = {1'b0, base};
        n = 0;
        exp_found = 1'b0;
        for (int i = 0; i < MAX_ATT; i++) begin
            n++;
            if (n == succ) begin
                exp_found = 1'b1;
                break;
            end
            if (k + KW1'(STEP_I[d]) > {1'b0, KMAX[d]}) break;
            k = k + KW1'(STEP_I[d]);
        end
        exp_key = k[KW-1:0];

        for (int a = 0; a < n; a++) begin
            cand = base + KW'(a * STEP_I[d]);
            for (int p = 0; p < 3; p++) begin
                lat[a][p] = hold ? 1 : int'($urandom_range(1, 3));
                exp_val.push_back(ph_mode[p]);
                exp_len.push_back(lat[a][p] < 2 ? 2 : lat[a][p]);
                exp_k.push_back(cand);
                exp_val.push_back(M_IDLE);
                exp_len.push_back(1);
                exp_k.push_back(cand);
            end
        end

        fin_v[d] = hold ? 3'b111 : 3'b000;
        suc_v[d] = 1'b0;
        pulse_start(d, base);

        idx = 0; len = 0; cur = M_IDLE; run_key = '0; done = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            m = mode_v[d];
            if (cyc == 0) begin
                cur = m; len = 1; run_key = key_v[d];
            end else if (m === cur) begin
                len++;
            end else begin
                ev = (idx < exp_val.size()) ? exp_val[idx] : 6'h3F;
                el = (idx < exp_len.size()) ? exp_len[idx] : -1;
                ek = (idx < exp_k.size())   ? exp_k[idx]   : '1;
                checks++;
                if (cur !== ev || len != el || run_key !== ek) begin
                    errors++;
                    $display("FAIL %s run%0d: got mode=%h len=%0d key=%h, expected mode=%h len=%0d key=%h",
                             name, idx, cur, len, run_key, ev, el, ek);
                end
                idx++; cur = m; len = 1; run_key = key_v[d];
            end
            if (busy_v[d] !== 1'b1) begin
                done = 1'b1;
                break;
            end
            att = idx / 6;
            if (att >= n) att = n - 1;
            if (hold) begin
                fin_v[d] = 3'b111;
                suc_v[d] = (att + 1 == succ);
            end else begin
                fin_v[d] = 3'b000;
                suc_v[d] = 1'b0;
                if (m === M_INIT && len >= lat[att][0]) fin_v[d] = 3'b001;
                if (m === M_SHUF && len >= lat[att][1]) fin_v[d] = 3'b010;
                if (m === M_DECR && len >= lat[att][2]) begin
                    fin_v[d] = 3'b100;
                    suc_v[d] = (att + 1 == succ);
                end
            end
            @(negedge clk);
        end
        fin_v[d] = 3'b000;
        suc_v[d] = 1'b0;

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: busy never dropped, expected completion after %0d attempts", name, n);
        end
        checks++;
        if (idx != 6 * n - 1 || cur !== M_IDLE) begin
            errors++;
            $display("FAIL %s run_count: got runs=%0d last_mode=%h, expected runs=%0d last_mode=%h",
                     name, idx, cur, 6 * n - 1, M_IDLE);
        end
        checks++;
        if (found_v[d] !== exp_found || exh_v[d] !== !exp_found) begin
            errors++;
            $display("FAIL %s flags: got found=%b exhausted=%b, expected found=%b exhausted=%b",
                     name, found_v[d], exh_v[d], exp_found, !exp_found);
        end
        checks++;
        if (key_v[d] !== exp_key) begin
            errors++;
            $display("FAIL %s final_key: got %h, expected %h", name, key_v[d], exp_key);
        end
        checks++;
        if (att_v[d] !== KW'(n)) begin
            errors++;
            $display("FAIL %s attempts: got %0d, expected %0d", name, att_v[d], n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (mode_v[d] !== M_IDLE || key_v[d] !== '0 || busy_v[d] !== 1'b0 ||
                found_v[d] !== 1'b0 || exh_v[d] !== 1'b0 || att_v[d] !== '0) begin
                errors++;
                $display("FAIL reset_dut%0d: got mode=%h key=%h busy=%b found=%b exh=%b att=%h, expected all zero",
                         d, mode_v[d], key_v[d], busy_v[d], found_v[d], exh_v[d], att_v[d]);
            end
`ifdef KEYSEQ_WATCHDOG_EN
            checks++;
            if (fault_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_fault_dut%0d: got %b, expected 0", d, fault_v[d]);
            end
`endif
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_key_found();
        run_search(0, 24'h000010, 3, 1'b0, "key_found");
        checks++;
        if (key_v[0] !== 24'h000012 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL key_found_final: got key=%h busy=%b, expected key=000012 busy=0", key_v[0], busy_v[0]);
        end
    endtask

    task automatic test_abort_terminal();
        abort = 1'b1;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (found_v[0] !== 1'b1 || key_v[0] !== 24'h000012 || att_v[0] !== 24'd3 || mode_v[0] !== M_IDLE) begin
            errors++;
            $display("FAIL abort_in_found: got found=%b key=%h att=%0d mode=%h, expected found=1 key=000012 att=3 mode=0",
                     found_v[0], key_v[0], att_v[0], mode_v[0]);
        end
    endtask

    task automatic test_range_end();
        run_search(1, 24'h000004, 0, 1'b0, "range_end");
    endtask

    task automatic test_interleave_overflow();
        run_search(2, 24'h3FFFFD, 0, 1'b0, "interleave_overflow");
    endtask

    task automatic test_stale_finish();
        run_search(0, KW'($urandom_range(0, 24'h0FFFFF)), int'($urandom_range(1, 3)), 1'b1, "stale_finish");
    endtask

    task automatic test_bad_base();
        pulse_start(1, KW'($urandom_range(6, 24'hFFFFFF)));
        @(negedge clk);
        checks++;
        if (exh_v[1] !== 1'b1 || mode_v[1] !== M_IDLE || busy_v[1] !== 1'b0 ||
            found_v[1] !== 1'b0 || att_v[1] !== '0) begin
            errors++;
            $display("FAIL bad_base: got exh=%b mode=%h busy=%b found=%b att=%h, expected exh=1 mode=0 busy=0 found=0 att=0",
                     exh_v[1], mode_v[1], busy_v[1], found_v[1], att_v[1]);
        end
    endtask

    task automatic test_abort();
        bit ok;
        pulse_start(0, 24'h000020);
        advance_to(0, M_SHUF, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_reach_shuf: got mode=%h, expected %h within budget", mode_v[0], M_SHUF);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (mode_v[0] !== M_IDLE || busy_v[0] !== 1'b0 || key_v[0] !== 24'h000020 ||
            att_v[0] !== '0 || found_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_shuf: got mode=%h busy=%b key=%h att=%h found=%b, expected mode=0 busy=0 key=000020 att=0 found=0",
                     mode_v[0], busy_v[0], key_v[0], att_v[0], found_v[0]);
        end
        @(negedge clk);
        pulse_start(0, 24'h000000);
        checks++;
        if (mode_v[0] !== M_INIT || key_v[0] !== '0 || att_v[0] !== '0 || busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: got mode=%h key=%h att=%h busy=%b, expected mode=%h key=0 att=0 busy=1",
                     mode_v[0], key_v[0], att_v[0], busy_v[0], M_INIT);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        base_v[0]  = 24'h000055;
        start_v[0] = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        abort      = 1'b0;
        checks++;
        if (mode_v[0] !== M_IDLE || busy_v[0] !== 1'b0 || key_v[0] !== '0) begin
            errors++;
            $display("FAIL start_abort_idle: got mode=%h busy=%b key=%h, expected mode=0 busy=0 key=0",
                     mode_v[0], busy_v[0], key_v[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        pulse_start(0, 24'h000030);
        advance_to(0, M_DECR, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_mid_reach_decr: got mode=%h, expected %h within budget", mode_v[0], M_DECR);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (mode_v[0] !== M_IDLE || key_v[0] !== '0 || busy_v[0] !== 1'b0 ||
            found_v[0] !== 1'b0 || exh_v[0] !== 1'b0 || att_v[0] !== '0) begin
            errors++;
            $display("FAIL reset_mid: got mode=%h key=%h busy=%b found=%b exh=%b att=%h, expected all zero",
                     mode_v[0], key_v[0], busy_v[0], found_v[0], exh_v[0], att_v[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_search(0, KW'($urandom_range(0, 24'h3FFFEF)), int'($urandom_range(1, 5)), 1'b0, "rand_found");
            run_search(0, 24'h3FFFFF - KW'($urandom_range(0, 3)), 0, 1'b0, "rand_top");
            run_search(1, KW'($urandom_range(0, 5)), 0, 1'b0, "rand_short");
            run_search(2, 24'h3FFFFF - KW'($urandom_range(0, 12)), 0, 1'b0, "rand_step4");
        end
    endtask

`ifdef KEYSEQ_WATCHDOG_EN
    task automatic test_watchdog();
        bit ok;
        int shuf_cycles;
        pulse_start(0, 24'h000040);
        advance_to(0, M_SHUF, ok);
        shuf_cycles = 0;
        for (int i = 0; i < 100 && mode_v[0] === M_SHUF; i++) begin
            shuf_cycles++;
            @(negedge clk);
        end
        checks++;
        if (!ok || shuf_cycles != 16 || fault_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || mode_v[0] !== M_IDLE) begin
            errors++;
            $display("FAIL watchdog: got shuf_cycles=%0d fault=%b busy=%b mode=%h, expected 16 fault=1 busy=0 mode=0",
                     shuf_cycles, fault_v[0], busy_v[0], mode_v[0]);
        end
        pulse_start(0, 24'h000000);
        checks++;
        if (fault_v[0] !== 1'b0 || mode_v[0] !== M_INIT) begin
            errors++;
            $display("FAIL watchdog_restart: got fault=%b mode=%h, expected fault=0 mode=%h",
                     fault_v[0], mode_v[0], M_INIT);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b0;
        abort = 1'b0;
        for (int d = 0; d < ND; d++) begin
            start_v[d] = 1'b0;
            base_v[d]  = '0;
            fin_v[d]   = 3'b000;
            suc_v[d]   = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_key_found();
        test_abort_terminal();
        test_range_end();
        test_interleave_overflow();
        test_stale_finish();
        test_bad_base();
        test_abort();
        test_reset_mid();
        test_random();
`ifdef KEYSEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400us;
        $display("FAIL global_timeout: simulation did not complete, expected completion before 400us");
        $fatal(1, "global timeout");
    end

endmodule
